sdf_butterfly: RTL and testbench
================================

SDF_BUTTERFLY -- requirements
Module: sdf_butterfly

Interface
REQ-001 SHALL have parameter WIDTH, default 32, two's-complement width of each real/imag sample.
REQ-002 SHALL have parameter DEPTH, default 32, length of the external feedback delay line; power of two, >= 2.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_real/in_imag carry a sample this cycle.
REQ-006 SHALL have port in_real, in_imag  input  WIDTH each  new sample from the upstream stage.
REQ-007 SHALL have port flush  input  1  inject zero samples to drain stored differences.
REQ-008 SHALL have port dly_real, dly_imag  input  WIDTH each  tap from the delay-line output.
REQ-009 SHALL have port dly_en  output  1  shift enable to the delay line.
REQ-010 SHALL have port to_dly_real, to_dly_imag  output  WIDTH each  data written into the delay line.
REQ-011 SHALL have port out_valid  output  1  out_real/out_imag valid this cycle.
REQ-012 SHALL have port out_real, out_imag  output  WIDTH each  butterfly result to the downstream stage.

Function
REQ-013 SHALL accept a sample ("step") when in_valid=1, or when flush=1 and in_valid=0 with in_real=in_imag=0 substituted.
REQ-014 SHALL keep cnt, log2(2*DEPTH) bits, incrementing by 1 per step and wrapping 2*DEPTH-1 -> 0; no change without a step.
REQ-015 SHALL be in phase FILL when cnt < DEPTH and phase BFLY when cnt >= DEPTH (cnt MSB).
REQ-016 SHALL drive dly_en combinationally equal to step.
REQ-017 FILL: to_dly = input sample (combinational); result = dly tap, passed through unscaled.
REQ-018 BFLY: sum = dly + input and diff = dly - input, each computed at WIDTH+1 bits; to_dly = diff(reduced per REQ-028/029), result = sum(reduced).
REQ-019 SHALL register result into out_real/out_imag on a step: latency exactly 1 cycle from step to output; outputs hold when no step.
REQ-020 SHALL keep flag primed, set on the first step with cnt = DEPTH-1 -> DEPTH, cleared only by reset.
REQ-021 SHALL register out_valid = step AND (primed OR phase BFLY); first DEPTH FILL outputs after reset are never valid.
REQ-022 in_valid and flush both high: in_valid wins, real data used, flush ignored.
REQ-023 flush with primed=0 and phase FILL: steps advance cnt, out_valid stays 0.
REQ-024 No backpressure: downstream SHALL accept every out_valid cycle.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear cnt, primed, out_valid, out_real, out_imag to 0.
REQ-026 Reset mid-frame SHALL discard the frame; delay-line contents are unreset and are masked by primed=0 until DEPTH new steps occur.
REQ-027 First step after reset_n release SHALL be treated as cnt=0 (FILL).

Configuration
REQ-028 With macro SDF_BUTTERFLY_SCALE_EN defined, sum and diff SHALL be arithmetic-shifted right by 1 (truncate toward -inf) to WIDTH bits.
REQ-029 Without SDF_BUTTERFLY_SCALE_EN, sum and diff SHALL keep the low WIDTH bits (wrap on overflow); all other behaviour identical.

Verification (WIDTH=16, DEPTH=4, delay line modelled as 4-deep shift on dly_en)
REQ-030 Reset: assert reset_n=0 mid-stream -> out_valid, out_real, out_imag = 0 same cycle; cnt restarts at 0; next 4 steps give out_valid=0.
REQ-031 Frame: real inputs 1..8, imag 0, continuous, no scale -> cycles 6..9 out_real = 6,8,10,12 valid; following frame FILL outputs -4,-4,-4,-4 valid.
REQ-032 Scale on: inputs 1..8 -> BFLY out_real = 3,4,5,6; stored diffs -2,-2,-2,-2.
REQ-033 Overflow: dly=0x7FFF, in=0x0001 BFLY -> no scale out_real=0x8000; scale on out_real=0x4000.
REQ-034 Gaps: in_valid toggled 1,0,1,0 through a frame -> cnt and outputs frozen on idle cycles, results match REQ-031 values.
REQ-035 Flush: after frame 1..8, flush=1 for 4 cycles, in_valid=0 -> out_real = -4 x4 valid; flush with in_valid=1 uses real data.

Source files
------------

// File: rtl/sdf_butterfly_if.sv
// Stream + delay-line bundle for one radix-2 SDF butterfly stage.
// The slave side is the butterfly; the master side is the surrounding pipeline.
interface sdf_butterfly_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             flush;
  logic [WIDTH-1:0] in_real;
  logic [WIDTH-1:0] in_imag;
  logic [WIDTH-1:0] dly_real;
  logic [WIDTH-1:0] dly_imag;
  logic             dly_en;
  logic [WIDTH-1:0] to_dly_real;
  logic [WIDTH-1:0] to_dly_imag;
  logic             out_valid;
  logic [WIDTH-1:0] out_real;
  logic [WIDTH-1:0] out_imag;

  modport master (
    output in_valid, flush, in_real, in_imag, dly_real, dly_imag,
    input  dly_en, to_dly_real, to_dly_imag, out_valid, out_real, out_imag
  );

  modport slave (
    input  in_valid, flush, in_real, in_imag, dly_real, dly_imag,
    output dly_en, to_dly_real, to_dly_imag, out_valid, out_real, out_imag
  );
endinterface

// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly with an external delay line.
// Define SDF_BUTTERFLY_SCALE_EN to halve sum/diff (arith shift) instead of wrapping.

module sdf_bfly_lane #(parameter int WIDTH = 32) (
  input  logic             bfly,
  input  logic [WIDTH-1:0] smp,
  input  logic [WIDTH-1:0] dly,
  output logic [WIDTH-1:0] to_dly,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH:0]   sum_x, diff_x;
  logic [WIDTH-1:0] sum_n, diff_n;
  logic             unused_bits;

  assign sum_x  = {dly[WIDTH-1], dly} + {smp[WIDTH-1], smp};
  assign diff_x = {dly[WIDTH-1], dly} - {smp[WIDTH-1], smp};

`ifdef SDF_BUTTERFLY_SCALE_EN
  assign sum_n       = sum_x[WIDTH:1];
  assign diff_n      = diff_x[WIDTH:1];
  assign unused_bits = sum_x[0] ^ diff_x[0];
`else
  assign sum_n       = sum_x[WIDTH-1:0];
  assign diff_n      = diff_x[WIDTH-1:0];
  assign unused_bits = sum_x[WIDTH] ^ diff_x[WIDTH];
`endif

  // FILL stores the new sample and forwards the old difference untouched.
  assign to_dly = bfly ? diff_n : smp;
  assign res    = bfly ? sum_n  : dly;
endmodule

module sdf_butterfly #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  sdf_butterfly_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(2 * DEPTH);

  logic [CW-1:0]                     cnt;
  logic                              primed;
  logic                              step;
  logic                              bfly;
  logic [NUM_LANES-1:0][WIDTH-1:0]   smp, dly, to_dly, res;

  // Flush-only steps inject zeros so stored differences drain out.
  assign step   = bus.in_valid | bus.flush;
  assign smp[0] = bus.in_valid ? bus.in_real : '0;
  assign smp[1] = bus.in_valid ? bus.in_imag : '0;
  assign dly[0] = bus.dly_real;
  assign dly[1] = bus.dly_imag;
  assign bfly   = cnt[CW-1];

  assign bus.dly_en      = step;
  assign bus.to_dly_real = to_dly[0];
  assign bus.to_dly_imag = to_dly[1];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sdf_bfly_lane #(.WIDTH(WIDTH)) u_lane (
      .bfly   (bfly),
      .smp    (smp[l]),
      .dly    (dly[l]),
      .to_dly (to_dly[l]),
      .res    (res[l])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      primed        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_real  <= '0;
      bus.out_imag  <= '0;
    end else begin
      // primed is sampled before its own update so the first FILL pass stays invalid.
      bus.out_valid <= step & (primed | bfly);
      if (step) begin
        cnt          <= cnt + 1'b1;
        bus.out_real <= res[0];
        bus.out_imag <= res[1];
        if (cnt == CW'(DEPTH - 1)) primed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdf_butterfly.sv
// Directed bench for sdf_butterfly (WIDTH=16, DEPTH=4) with a 4-deep delay-line model.
module tb_sdf_butterfly;
  localparam int W = 16;
  localparam int D = 4;
`ifdef SDF_BUTTERFLY_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   passed  = 0;
  int   total   = 0;

  always #5 clock = ~clock;

  sdf_butterfly_if #(.WIDTH(W)) bus ();

  sdf_butterfly #(.WIDTH(W), .DEPTH(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External delay line: unreset, shifts on dly_en, tap is the oldest entry.
  logic [W-1:0] dl_r [D] = '{default: '0};
  logic [W-1:0] dl_i [D] = '{default: '0};
  always @(posedge clock) begin
    if (bus.dly_en) begin
      for (int i = D - 1; i > 0; i--) begin
        dl_r[i] <= dl_r[i-1];
        dl_i[i] <= dl_i[i-1];
      end
      dl_r[0] <= bus.to_dly_real;
      dl_i[0] <= bus.to_dly_imag;
    end
  end
  assign bus.dly_real = dl_r[D-1];
  assign bus.dly_imag = dl_i[D-1];

  task automatic drive(input logic v, input logic f, input logic [W-1:0] re, input logic [W-1:0] im);
    bus.in_valid = v;
    bus.flush    = f;
    bus.in_real  = re;
    bus.in_imag  = im;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.flush = 0; bus.in_real = '0; bus.in_imag = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b0, 16'h0, 16'h0}) begin
      $display("FAIL reset_state: got v=%b r=%h i=%h, want 0/0/0", bus.out_valid, bus.out_real, bus.out_imag);
    end else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [W-1:0] e;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, W'(i), '0);
      total++;
      if (i <= 4) begin
        if (bus.out_valid !== 1'b0) begin
          $display("FAIL frame_fill%0d: got v=%b, want v=0", i, bus.out_valid);
        end else passed++;
      end else begin
        e = SCALE ? W'(i - 2) : W'(2 * i - 4);
        if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b1, e, 16'h0}) begin
          $display("FAIL frame_bfly%0d: got v=%b r=%0d i=%0d, want v=1 r=%0d i=0",
                   i, bus.out_valid, $signed(bus.out_real), $signed(bus.out_imag), $signed(e));
        end else passed++;
      end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] e, ei;
    e = SCALE ? W'(-2) : W'(-4);
    // Non-zero data on the bus must be ignored while in_valid is low.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'd5, 16'd5);
      total++;
      if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b1, e, 16'h0}) begin
        $display("FAIL flush_drain%0d: got v=%b r=%0d i=%0d, want v=1 r=%0d i=0",
                 i, bus.out_valid, $signed(bus.out_real), $signed(bus.out_imag), $signed(e));
      end else passed++;
    end
    // in_valid wins over flush; tap holds the zeros written during the flush.
    drive(1'b1, 1'b1, 16'd7, 16'd3);
    e  = SCALE ? 16'd3 : 16'd7;
    ei = SCALE ? 16'd1 : 16'd3;
    total++;
    if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b1, e, ei}) begin
      $display("FAIL flush_valid_wins: got v=%b r=%0d i=%0d, want v=1 r=%0d i=%0d",
               bus.out_valid, $signed(bus.out_real), $signed(bus.out_imag), $signed(e), $signed(ei));
    end else passed++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 16'd1, 16'd0);
    drive(1'b1, 1'b0, 16'd2, 16'd0);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b0, 16'h0, 16'h0}) begin
      $display("FAIL reset_async: got v=%b r=%h i=%h, want 0/0/0", bus.out_valid, bus.out_real, bus.out_imag);
    end else passed++;
    bus.in_valid = 0; bus.flush = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Alternate steps and idle cycles right after a reset (stale delay contents).
  task automatic test_gaps();
    logic [W-1:0] e;
    logic [W-1:0] last;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, W'(i), '0);
      total++;
      if (i <= 4) begin
        if (bus.out_valid !== 1'b0) begin
          $display("FAIL gaps_fill%0d: got v=%b, want v=0", i, bus.out_valid);
        end else passed++;
      end else begin
        e = SCALE ? W'(i - 2) : W'(2 * i - 4);
        if ({bus.out_valid, bus.out_real} !== {1'b1, e}) begin
          $display("FAIL gaps_bfly%0d: got v=%b r=%0d, want v=1 r=%0d",
                   i, bus.out_valid, $signed(bus.out_real), $signed(e));
        end else passed++;
      end
      last = bus.out_real;
      drive(1'b0, 1'b0, 16'd99, 16'd99);
      total++;
      if ({bus.out_valid, bus.out_real, bus.dly_en} !== {1'b0, last, 1'b0}) begin
        $display("FAIL gaps_idle%0d: got v=%b r=%0d en=%b, want v=0 r=%0d en=0",
                 i, bus.out_valid, $signed(bus.out_real), bus.dly_en, $signed(last));
      end else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e, ei;
    e = SCALE ? W'(-2) : W'(-4);
    // Next frame's FILL pass drains the previous frame's differences.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h7FFF, 16'h8000);
      total++;
      if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b1, e, 16'h0}) begin
        $display("FAIL next_fill%0d: got v=%b r=%0d i=%0d, want v=1 r=%0d i=0",
                 i, bus.out_valid, $signed(bus.out_real), $signed(bus.out_imag), $signed(e));
      end else passed++;
    end
    drive(1'b1, 1'b0, 16'h0001, 16'hFFFF);
    e  = SCALE ? 16'h4000 : 16'h8000;
    ei = SCALE ? 16'hBFFF : 16'h7FFF;
    total++;
    if ({bus.out_valid, bus.out_real, bus.out_imag} !== {1'b1, e, ei}) begin
      $display("FAIL overflow: got v=%b r=%h i=%h, want v=1 r=%h i=%h",
               bus.out_valid, bus.out_real, bus.out_imag, e, ei);
    end else passed++;
  endtask

  task automatic test_flush_unprimed();
    logic [W-1:0] e;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'd9, 16'd9);
      total++;
      if (bus.out_valid !== 1'b0) begin
        $display("FAIL unprimed_flush%0d: got v=%b, want v=0", i, bus.out_valid);
      end else passed++;
    end
    // Flush steps advanced cnt, so these land in BFLY against zeros.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, W'(2 * i), '0);
      e = SCALE ? W'(i) : W'(2 * i);
      total++;
      if ({bus.out_valid, bus.out_real} !== {1'b1, e}) begin
        $display("FAIL unprimed_bfly%0d: got v=%b r=%0d, want v=1 r=%0d",
                 i, bus.out_valid, $signed(bus.out_real), $signed(e));
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_flush();
    test_reset_mid();
    test_gaps();
    test_overflow();
    test_flush_unprimed();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
